// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for nibble_serial_subtractor.
// Define SUB_OVERFLOW_EN to add the OVF signal.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             OVF;
`endif

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
`ifdef SUB_OVERFLOW_EN
        output OVF,
`endif
        output in_ready, out_valid, Diff, Bout
    );

    modport master (
        output in_valid, A, B, Bin, out_ready,
`ifdef SUB_OVERFLOW_EN
        input  OVF,
`endif
        input  in_ready, out_valid, Diff, Bout
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: A - B - Bin one nibble per cycle, LSB nibble first.
// Define SUB_OVERFLOW_EN to add the two's-complement OVF output.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst,
    nibble_serial_subtractor_if.slave sub
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;

    logic [IDXW+1:0]  base;
    logic [3:0]       na, nb, g, p, nd;
    logic [4:0]       bw;

    assign base = {idx_q, 2'b00};
    assign na   = a_q[base +: 4];
    assign nb   = b_q[base +: 4];
    assign g    = ~na & nb;
    assign p    = ~(na ^ nb);

    // Each nibble borrow is flattened from the registered borrow, not rippled
    always_comb begin
        bw[0] = borrow_q;
        bw[1] = g[0] | (p[0] & borrow_q);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_q);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & borrow_q);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & borrow_q);
        nd    = na ^ nb ^ bw[3:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (sub.in_valid) begin
                    a_d      = sub.A;
                    b_d      = sub.B;
                    borrow_d = sub.Bin;
                    idx_d    = '0;
                    diff_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[base +: 4] = nd;
                borrow_d          = bw[4];
                idx_d             = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    bout_d  = bw[4];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sub.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign sub.in_ready  = (state_q == IDLE);
    assign sub.out_valid = (state_q == DONE);
    assign sub.Diff      = diff_q;
    assign sub.Bout      = bout_q;

`ifdef SUB_OVERFLOW_EN
    // Operands stay latched through DONE, so OVF holds with Diff
    assign sub.OVF = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
endmodule
